// File: rtl/reg_stat_n_pkg.sv
// Shared constants for the register status table.
package reg_stat_n_pkg;
    // Tag value meaning "no producer pending".
    localparam int UNLOCKED = 0;
    // Named producer tags carried over from the single-issue table.
    localparam int ALU_MASTER = 1;
    localparam int ALU_SALVER = 2;
    localparam int LOAD_STORE = 3;
    // Widest data word; narrowed at use with a size cast.
    localparam logic [63:0] ZERO = 64'h0;
endpackage

// File: rtl/reg_stat_n_if.sv
// Dispatch-side bus of the register status table: reads, renames, writebacks.
interface reg_stat_n_if #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int TAG_W     = 3,
    parameter int NUM_RD    = 4,
    parameter int NUM_REN   = 2,
    parameter int NUM_WB    = 3
);
    localparam int AW = $clog2(REG_COUNT);
    localparam int CW = $clog2(REG_COUNT + 1);

    logic                              rdy;
    logic                              flush;
    logic [NUM_RD-1:0]                 rd_en;
    logic [NUM_RD-1:0][AW-1:0]         rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]       rd_imm;
    logic [NUM_RD-1:0][XLEN-1:0]       rd_data;
    logic [NUM_RD-1:0][TAG_W-1:0]      rd_tag;
    logic [NUM_REN-1:0]                ren_en;
    logic [NUM_REN-1:0][AW-1:0]        ren_addr;
    logic [NUM_REN-1:0][TAG_W-1:0]     ren_tag;
    logic [NUM_REN-1:0][TAG_W-1:0]     ren_prev_tag;
    logic [NUM_WB-1:0]                 wb_en;
    logic [NUM_WB-1:0][AW-1:0]         wb_addr;
    logic [NUM_WB-1:0][TAG_W-1:0]      wb_tag;
    logic [NUM_WB-1:0][XLEN-1:0]       wb_data;
    logic [CW-1:0]                     lock_count;

    modport master (
        output rdy, flush, rd_en, rd_addr, rd_imm, ren_en, ren_addr, ren_tag,
               wb_en, wb_addr, wb_tag, wb_data,
        input  rd_data, rd_tag, ren_prev_tag, lock_count
    );

    modport slave (
        input  rdy, flush, rd_en, rd_addr, rd_imm, ren_en, ren_addr, ren_tag,
               wb_en, wb_addr, wb_tag, wb_data,
        output rd_data, rd_tag, ren_prev_tag, lock_count
    );
endinterface

// File: rtl/reg_stat_n_wb_match.sv
// Finds the writeback channel that owns a register: address hit, tag equal to
// the register's current nonzero tag; the highest-index hit wins.
module reg_stat_n_wb_match #(
    parameter int AW     = 5,
    parameter int TAG_W  = 3,
    parameter int NUM_WB = 3,
    parameter int IW     = 2
) (
    input  logic [NUM_WB-1:0]             wb_en_i,
    input  logic [NUM_WB-1:0][AW-1:0]     wb_addr_i,
    input  logic [NUM_WB-1:0][TAG_W-1:0]  wb_tag_i,
    input  logic [AW-1:0]                 addr_i,
    input  logic [TAG_W-1:0]              cur_tag_i,
    output logic                          hit_o,
    output logic [IW-1:0]                 idx_o
);
    // Ascending scan so later channels override earlier ones.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_en_i[i] && wb_addr_i[i] == addr_i &&
                wb_tag_i[i] == cur_tag_i && cur_tag_i != '0) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end
endmodule

// File: rtl/reg_stat_n.sv
// Multi-issue register status table: values plus producer tags, with
// same-cycle writeback bypass, in-order bundle rename and flush recovery.
module reg_stat_n
    import reg_stat_n_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int TAG_W     = 3,
    parameter int NUM_RD    = 4,
    parameter int NUM_REN   = 2,
    parameter int NUM_WB    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_stat_n_if.slave  bus
);
    localparam int AW    = $clog2(REG_COUNT);
    localparam int CW    = $clog2(REG_COUNT + 1);
    localparam int DEPTH = 1 << AW;   // unused slots above REG_COUNT stay zero
    localparam int IW    = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0]  word_t;
    typedef logic [AW-1:0]    regaddr_t;

    tag_t  [DEPTH-1:0] tag_q,  tag_d;
    word_t [DEPTH-1:0] data_q, data_d;
    logic  [CW-1:0]    lock_q;

    function automatic logic [CW-1:0] popcount(input tag_t [DEPTH-1:0] t);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) n = n + CW'(t[i] != tag_t'(UNLOCKED));
        return n;
    endfunction

    // Read ports: immediate, bypassed writeback, or stored state (pre-rename).
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        tag_t          cur;
        logic          hit;
        logic [IW-1:0] idx;
        assign cur = tag_q[bus.rd_addr[p]];
        reg_stat_n_wb_match #(.AW(AW), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .IW(IW)) u_byp (
            .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_tag_i(bus.wb_tag),
            .addr_i(bus.rd_addr[p]), .cur_tag_i(cur), .hit_o(hit), .idx_o(idx)
        );
        assign bus.rd_data[p] = !bus.rd_en[p] ? bus.rd_imm[p] :
                                hit ? bus.wb_data[idx] : data_q[bus.rd_addr[p]];
        assign bus.rd_tag[p]  = (!bus.rd_en[p] || hit) ? tag_t'(UNLOCKED) : cur;
    end

    // Previous tag per rename slot, seeing earlier slots of the same bundle.
    for (genvar j = 0; j < NUM_REN; j++) begin : g_prev
        tag_t pt;
        always_comb begin
            pt = tag_q[bus.ren_addr[j]];
            for (int k = 0; k < j; k++) begin
                if (bus.ren_en[k] && bus.ren_addr[k] == bus.ren_addr[j] &&
                    bus.ren_addr[j] != '0)
                    pt = bus.ren_tag[k];
            end
        end
        assign bus.ren_prev_tag[j] = pt;
    end

    // Per-register next state: flush > rename > writeback commit.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if (r == 0 || r >= REG_COUNT) begin : g_const
            assign tag_d[r]  = tag_t'(UNLOCKED);
            assign data_d[r] = word_t'(ZERO);
        end else begin : g_live
            logic          cm_hit, ren_hit;
            logic [IW-1:0] cm_idx;
            tag_t          ren_val, nx_tag;
            word_t         nx_data;
            reg_stat_n_wb_match #(.AW(AW), .TAG_W(TAG_W), .NUM_WB(NUM_WB), .IW(IW)) u_cm (
                .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_tag_i(bus.wb_tag),
                .addr_i(regaddr_t'(r)), .cur_tag_i(tag_q[r]), .hit_o(cm_hit), .idx_o(cm_idx)
            );
            // Last rename slot targeting this register supplies the new tag.
            always_comb begin
                ren_hit = 1'b0;
                ren_val = tag_t'(UNLOCKED);
                for (int s = 0; s < NUM_REN; s++) begin
                    if (bus.ren_en[s] && bus.ren_addr[s] == regaddr_t'(r)) begin
                        ren_hit = 1'b1;
                        ren_val = bus.ren_tag[s];
                    end
                end
                nx_tag  = tag_q[r];
                nx_data = data_q[r];
                if (bus.flush) begin
                    nx_tag = tag_t'(UNLOCKED);
                    if (cm_hit) nx_data = bus.wb_data[cm_idx];
                end else if (ren_hit) begin
                    nx_tag = ren_val;
                end else if (cm_hit) begin
                    nx_data = bus.wb_data[cm_idx];
                    nx_tag  = tag_t'(UNLOCKED);
                end
            end
            assign tag_d[r]  = nx_tag;
            assign data_d[r] = nx_data;
        end
    end

    // State and lock count advance together only when the stage is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q  <= '0;
            data_q <= '0;
            lock_q <= '0;
        end else if (bus.rdy) begin
            tag_q  <= tag_d;
            data_q <= data_d;
            lock_q <= popcount(tag_d);
        end
    end

    assign bus.lock_count = lock_q;
endmodule

// File: tb/tb_reg_stat_n.sv
// Bench for reg_stat_n: directed scenarios plus randomized traffic against
// an array-based reference model of the status table.
module tb_reg_stat_n;
    localparam int XLEN = 32, RC = 32, TW = 3, NRD = 4, NREN = 2, NWB = 3;

    logic clk, rst_n;
    int nvec = 0, nerr = 0;

    logic [XLEN-1:0] mdata [RC];
    logic [TW-1:0]   mtag  [RC];
    int              mlock;

    reg_stat_n_if #(.XLEN(XLEN), .REG_COUNT(RC), .TAG_W(TW), .NUM_RD(NRD),
                    .NUM_REN(NREN), .NUM_WB(NWB)) bus ();

    reg_stat_n #(.XLEN(XLEN), .REG_COUNT(RC), .TAG_W(TW), .NUM_RD(NRD),
                 .NUM_REN(NREN), .NUM_WB(NWB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int r = 0; r < RC; r++) begin mdata[r] = '0; mtag[r] = '0; end
        mlock = 0;
    endtask

    task automatic idle();
        bus.rdy = 1'b1; bus.flush = 1'b0;
        bus.rd_en = '0; bus.rd_addr = '0; bus.rd_imm = '0;
        bus.ren_en = '0; bus.ren_addr = '0; bus.ren_tag = '0;
        bus.wb_en = '0; bus.wb_addr = '0; bus.wb_tag = '0; bus.wb_data = '0;
    endtask

    task automatic rd(input int p, input int a);
        bus.rd_en[p] = 1'b1; bus.rd_addr[p] = 5'(a);
    endtask
    task automatic ren(input int s, input int a, input int t);
        bus.ren_en[s] = 1'b1; bus.ren_addr[s] = 5'(a); bus.ren_tag[s] = 3'(t);
    endtask
    task automatic wb(input int c, input int a, input int t, input logic [31:0] d);
        bus.wb_en[c] = 1'b1; bus.wb_addr[c] = 5'(a); bus.wb_tag[c] = 3'(t); bus.wb_data[c] = d;
    endtask

    // Expected read port result from the model and the current inputs.
    function automatic void exp_rd(input int p, output logic [31:0] d, output logic [2:0] t);
        int a;
        a = int'(bus.rd_addr[p]);
        if (!bus.rd_en[p]) begin d = bus.rd_imm[p]; t = '0; return; end
        d = mdata[a]; t = mtag[a];
        for (int c = 0; c < NWB; c++)
            if (bus.wb_en[c] && int'(bus.wb_addr[c]) == a && mtag[a] != 0 &&
                bus.wb_tag[c] == mtag[a]) begin
                d = bus.wb_data[c]; t = '0;
            end
    endfunction

    // Apply the bundle slot by slot on a scratch copy of the tag table.
    function automatic logic [2:0] exp_prev(input int j);
        logic [2:0] tmp [RC];
        tmp = mtag;
        for (int k = 0; k < j; k++)
            if (bus.ren_en[k] && bus.ren_addr[k] != 0) tmp[bus.ren_addr[k]] = bus.ren_tag[k];
        return tmp[bus.ren_addr[j]];
    endfunction

    // One clock edge; model follows the rules at the same edge.
    task automatic cycle();
        logic [31:0] nd [RC];
        logic [2:0]  nt [RC];
        int win, rn, cnt;
        nd = mdata; nt = mtag;
        if (bus.rdy && rst_n) begin
            for (int r = 1; r < RC; r++) begin
                win = -1; rn = -1;
                for (int c = 0; c < NWB; c++)
                    if (bus.wb_en[c] && int'(bus.wb_addr[c]) == r && mtag[r] != 0 &&
                        bus.wb_tag[c] == mtag[r]) win = c;
                for (int s = 0; s < NREN; s++)
                    if (bus.ren_en[s] && int'(bus.ren_addr[s]) == r) rn = s;
                if (bus.flush) begin
                    nt[r] = '0;
                    if (win >= 0) nd[r] = bus.wb_data[win];
                end else if (rn >= 0) nt[r] = bus.ren_tag[rn];
                else if (win >= 0) begin nd[r] = bus.wb_data[win]; nt[r] = '0; end
            end
        end
        @(posedge clk);
        if (bus.rdy && rst_n) begin
            mdata = nd; mtag = nt;
            cnt = 0;
            for (int r = 0; r < RC; r++) if (nt[r] != 0) cnt++;
            mlock = cnt;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(0, 5); bus.rd_imm[1] = 32'h1234; #1;
        nvec++; if (bus.rd_data[0] !== 32'h0) begin nerr++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data[0]); end
        nvec++; if (bus.rd_tag[0] !== 3'd0) begin nerr++; $display("FAIL reset_rd_tag got %0d want 0", bus.rd_tag[0]); end
        nvec++; if (bus.lock_count !== 6'd0) begin nerr++; $display("FAIL reset_lock got %0d want 0", bus.lock_count); end
        nvec++; if (bus.rd_data[1] !== 32'h1234 || bus.rd_tag[1] !== 3'd0) begin nerr++; $display("FAIL reset_imm got %h/%0d want 1234/0", bus.rd_data[1], bus.rd_tag[1]); end
    endtask

    task automatic test_rename_wb();
        idle(); ren(0, 3, 2); cycle();
        idle(); rd(0, 3); #1;
        nvec++; if (bus.rd_tag[0] !== 3'd2 || bus.lock_count !== 6'd1) begin nerr++; $display("FAIL ren_locked got tag %0d lock %0d want 2/1", bus.rd_tag[0], bus.lock_count); end
        wb(0, 3, 2, 32'hAB); #1;
        nvec++; if (bus.rd_data[0] !== 32'hAB || bus.rd_tag[0] !== 3'd0) begin nerr++; $display("FAIL wb_bypass got %h/%0d want ab/0", bus.rd_data[0], bus.rd_tag[0]); end
        cycle();
        idle(); rd(0, 3); #1;
        nvec++; if (bus.rd_data[0] !== 32'hAB || bus.rd_tag[0] !== 3'd0 || bus.lock_count !== 6'd0) begin nerr++; $display("FAIL wb_commit got %h/%0d lock %0d want ab/0/0", bus.rd_data[0], bus.rd_tag[0], bus.lock_count); end
    endtask

    task automatic test_stale_wb();
        idle(); ren(0, 3, 2); cycle();
        idle(); ren(0, 3, 4); cycle();
        idle(); wb(0, 3, 2, 32'h11); rd(0, 3); #1;
        nvec++; if (bus.rd_data[0] !== 32'hAB || bus.rd_tag[0] !== 3'd4) begin nerr++; $display("FAIL stale_nobypass got %h/%0d want ab/4", bus.rd_data[0], bus.rd_tag[0]); end
        cycle();
        idle(); rd(0, 3); #1;
        nvec++; if (bus.rd_data[0] !== 32'hAB || bus.rd_tag[0] !== 3'd4) begin nerr++; $display("FAIL stale_dropped got %h/%0d want ab/4", bus.rd_data[0], bus.rd_tag[0]); end
        wb(1, 3, 4, 32'h44); cycle();
        idle(); #1;
        nvec++; if (bus.lock_count !== 6'd0) begin nerr++; $display("FAIL stale_cleanup lock %0d want 0", bus.lock_count); end
    endtask

    task automatic test_same_bundle();
        idle(); ren(0, 7, 1); ren(1, 7, 3); #1;
        nvec++; if (bus.ren_prev_tag[0] !== 3'd0 || bus.ren_prev_tag[1] !== 3'd1) begin nerr++; $display("FAIL bundle_prev got %0d,%0d want 0,1", bus.ren_prev_tag[0], bus.ren_prev_tag[1]); end
        cycle();
        idle(); rd(2, 7); #1;
        nvec++; if (bus.rd_tag[2] !== 3'd3 || bus.lock_count !== 6'd1) begin nerr++; $display("FAIL bundle_final got tag %0d lock %0d want 3/1", bus.rd_tag[2], bus.lock_count); end
        wb(2, 7, 3, 32'h70); cycle();
    endtask

    task automatic test_flush();
        idle(); ren(0, 1, 1); ren(1, 2, 2); cycle();
        idle(); ren(0, 4, 3); cycle();
        idle(); #1;
        nvec++; if (bus.lock_count !== 6'd3) begin nerr++; $display("FAIL flush_pre lock %0d want 3", bus.lock_count); end
        bus.flush = 1'b1; ren(0, 9, 5); wb(1, 2, 2, 32'h77); cycle();
        idle(); rd(0, 2); rd(1, 9); rd(2, 1); rd(3, 4); #1;
        nvec++; if (bus.rd_data[0] !== 32'h77 || bus.rd_tag[0] !== 3'd0) begin nerr++; $display("FAIL flush_wb got %h/%0d want 77/0", bus.rd_data[0], bus.rd_tag[0]); end
        nvec++; if (bus.rd_tag[1] !== 3'd0 || bus.rd_tag[2] !== 3'd0 || bus.rd_tag[3] !== 3'd0) begin nerr++; $display("FAIL flush_tags got %0d,%0d,%0d want 0,0,0", bus.rd_tag[1], bus.rd_tag[2], bus.rd_tag[3]); end
        nvec++; if (bus.lock_count !== 6'd0) begin nerr++; $display("FAIL flush_lock got %0d want 0", bus.lock_count); end
    endtask

    task automatic test_rdy_r0();
        idle(); ren(0, 5, 6); cycle();
        idle(); bus.rdy = 1'b0; ren(0, 6, 2); wb(0, 5, 6, 32'h55); bus.flush = 1'b1; cycle();
        idle(); rd(0, 5); rd(1, 6); #1;
        nvec++; if (bus.rd_data[0] !== 32'h0 || bus.rd_tag[0] !== 3'd6 || bus.rd_tag[1] !== 3'd0 || bus.lock_count !== 6'd1) begin nerr++; $display("FAIL rdy_hold got %h/%0d r6 %0d lock %0d want 0/6/0/1", bus.rd_data[0], bus.rd_tag[0], bus.rd_tag[1], bus.lock_count); end
        idle(); ren(1, 0, 3); wb(0, 0, 3, 32'hFF); cycle();
        idle(); rd(0, 0); #1;
        nvec++; if (bus.rd_data[0] !== 32'h0 || bus.rd_tag[0] !== 3'd0 || bus.lock_count !== 6'd1) begin nerr++; $display("FAIL r0_ignored got %h/%0d lock %0d want 0/0/1", bus.rd_data[0], bus.rd_tag[0], bus.lock_count); end
        wb(0, 5, 6, 32'h55); cycle();
    endtask

    task automatic test_async_reset();
        idle(); ren(0, 10, 1); ren(1, 11, 2); cycle();
        idle(); wb(0, 10, 1, 32'hDEAD); cycle();
        idle(); rd(0, 10); rd(1, 11); #2;
        rst_n = 1'b0; #1;
        nvec++; if (bus.lock_count !== 6'd0 || bus.rd_data[0] !== 32'h0 || bus.rd_tag[1] !== 3'd0) begin nerr++; $display("FAIL async_clear got lock %0d r10 %h r11 %0d want 0/0/0", bus.lock_count, bus.rd_data[0], bus.rd_tag[1]); end
        model_reset(); #2;
        rst_n = 1'b1;
        idle(); ren(0, 12, 1); cycle();
        idle(); rd(0, 12); #1;
        nvec++; if (bus.rd_tag[0] !== 3'd1 || bus.lock_count !== 6'd1) begin nerr++; $display("FAIL post_reset got tag %0d lock %0d want 1/1", bus.rd_tag[0], bus.lock_count); end
        wb(0, 12, 1, 32'h12); cycle();
    endtask

    task automatic test_random();
        logic [31:0] ed; logic [2:0] et;
        int a;
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.rdy   = ($urandom_range(0, 9) != 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < NRD; p++) begin
                bus.rd_en[p] = ($urandom_range(0, 4) != 0);
                bus.rd_addr[p] = 5'($urandom_range(0, 7));
                bus.rd_imm[p] = $urandom;
            end
            for (int s = 0; s < NREN; s++)
                if ($urandom_range(0, 2) == 0) ren(s, $urandom_range(0, 7), $urandom_range(1, 7));
            for (int c = 0; c < NWB; c++)
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, 7);
                    wb(c, a, ($urandom_range(0, 3) != 0) ? int'(mtag[a]) : $urandom_range(1, 7), $urandom);
                end
            #1;
            for (int p = 0; p < NRD; p++) begin
                exp_rd(p, ed, et);
                nvec++; if (bus.rd_data[p] !== ed || bus.rd_tag[p] !== et) begin nerr++; $display("FAIL rand_rd[%0d] cyc %0d got %h/%0d want %h/%0d", p, n, bus.rd_data[p], bus.rd_tag[p], ed, et); end
            end
            for (int s = 0; s < NREN; s++) begin
                et = exp_prev(s);
                nvec++; if (bus.ren_prev_tag[s] !== et) begin nerr++; $display("FAIL rand_prev[%0d] cyc %0d got %0d want %0d", s, n, bus.ren_prev_tag[s], et); end
            end
            nvec++; if (int'(bus.lock_count) !== mlock) begin nerr++; $display("FAIL rand_lock cyc %0d got %0d want %0d", n, bus.lock_count, mlock); end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_rename_wb();
        test_stale_wb();
        test_same_bundle();
        test_flush();
        test_rdy_r0();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
